// File: rtl/mac_seq_ctrl.sv
// Sequencer for a 4-bit multiply-accumulate datapath: accepts len operand pairs, sums their products, pulses done.
// Optional saturating accumulator with sticky overflow flag: define MAC_SAT_EN.
module mac_seq_ctrl #(
    parameter int DW = 4,
    parameter int AW = 8,
    parameter int LW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [LW-1:0] len,
    output logic          busy,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] x,
    input  logic [DW-1:0] y,
    output logic          done,
    output logic [AW-1:0] result,
    output logic          ovf,
    output logic [1:0]    state_dbg
);

    // Stream handshake: a beat is in_valid && in_ready at a posedge. in_ready depends only on
    // state (never on in_valid). The source may raise/drop in_valid freely; nothing is buffered.

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [2*DW-1:0] prod_w;
    logic [AW-1:0]   prod;
    logic            prod_vld;
    logic [AW-1:0]   acc;
    logic [LW-1:0]   rem;
    logic            beat;
    logic            job_start;

    assign beat      = in_valid && in_ready;
    assign job_start = (state == S_IDLE) && start;
    assign prod_w    = {{DW{1'b0}}, x} * {{DW{1'b0}}, y};
    assign state_dbg = state;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (len != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (beat && (rem == LW'(1))) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        case (state)
            S_IDLE:  begin in_ready = 1'b0; busy = 1'b0; end
            S_RUN:   begin in_ready = 1'b1; busy = 1'b1; end
            S_DRAIN: begin in_ready = 1'b0; busy = 1'b1; end
            S_DONE:  begin in_ready = 1'b0; busy = 1'b1; end
            default: begin in_ready = 1'b0; busy = 1'b0; end
        endcase
    end

    // Product stage and remaining-pair counter
    always_ff @(posedge clk) begin
        if (reset) begin
            prod     <= '0;
            prod_vld <= 1'b0;
            rem      <= '0;
        end else begin
            if (beat) begin
                prod     <= AW'(prod_w);
                prod_vld <= 1'b1;
                rem      <= rem - LW'(1);
            end else begin
                prod_vld <= 1'b0;
            end
            if (job_start && (len != '0)) begin
                rem <= len;
            end
        end
    end

`ifdef MAC_SAT_EN
    logic [AW:0] sum_w;
    logic        sat;
    logic        ovf_q;

    assign sum_w = {1'b0, acc} + {1'b0, prod};

    // Once clamped, any further nonzero product carries out again, so acc stays at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
            sat <= 1'b0;
        end else if (job_start) begin
            acc <= '0;
            sat <= 1'b0;
        end else if (prod_vld) begin
            if (sum_w[AW]) begin
                acc <= '1;
                sat <= 1'b1;
            end else begin
                acc <= sum_w[AW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if (state == S_DONE) begin
            ovf_q <= sat;
        end
    end

    assign ovf = ovf_q;
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
        end else if (job_start) begin
            acc <= '0;
        end else if (prod_vld) begin
            acc <= acc + prod;
        end
    end

    assign ovf = 1'b0;
`endif

    // Result register holds the previous job's sum until the new job reaches DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            result <= '0;
            done   <= 1'b0;
        end else if (state == S_DONE) begin
            result <= acc;
            done   <= 1'b1;
        end else begin
            done   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Randomised self-checking bench for mac_seq_ctrl; reference sums come from plain integer arithmetic.
module tb_mac_seq_ctrl;
    localparam int DW = 4;
    localparam int AW = 8;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [LW-1:0] len;
    logic          busy;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] x;
    logic [DW-1:0] y;
    logic          done;
    logic [AW-1:0] result;
    logic          ovf;
    logic [1:0]    state_dbg;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [AW-1:0] exp_q[$];
    logic          exp_ovf_q[$];
    int            px[16];
    int            py[16];

    // Job outputs gathered by the driver
    int            j_done_cnt;
    int            j_lat;
    logic [AW-1:0] j_res;
    logic          j_ovf;
    bit            j_gap_bad;
    bit            j_busy_bad;
    bit            j_extra;
    bit            j_timeout;
    logic [AW-1:0] j_res_at_start;

    mac_seq_ctrl #(.DW(DW), .AW(AW), .LW(LW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .len       (len),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .done      (done),
        .result    (result),
        .ovf       (ovf),
        .state_dbg (state_dbg)
    );

    // Clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: sum of products of the first n pairs, wrapped or clamped to AW bits
    function automatic logic [AW:0] model_job(input int n);
        int sum;
        sum = 0;
        for (int i = 0; i < n; i++) sum += px[i] * py[i];
`ifdef MAC_SAT_EN
        if (sum > (2**AW) - 1) return {1'b1, AW'((2**AW) - 1)};
        return {1'b0, AW'(sum)};
`else
        return {1'b0, AW'(sum % (2**AW))};
`endif
    endfunction

    function automatic void push_expect(input int n);
        logic [AW:0] m;
        m = model_job(n);
        exp_q.push_back(m[AW-1:0]);
        exp_ovf_q.push_back(m[AW]);
    endfunction

    // Driver: run one job of n pairs from px/py, gaps of gap_min..gap_max idle cycles after each beat
    task automatic drive_job(input int n, input int gap_min, input int gap_max, input bit mid_start);
        int  i;
        int  gapc;
        int  last_edge;
        int  guard;
        bit  started_mid;
        bit  beat;
        i = 0; gapc = 0; guard = 0; started_mid = 0;
        j_done_cnt = 0; j_lat = -1; j_res = '0; j_ovf = 1'b0;
        j_gap_bad = 0; j_busy_bad = 0; j_extra = 0; j_timeout = 0;
        @(negedge clk);
        start = 1'b1;
        len   = LW'(n);
        @(posedge clk);
        #1;
        start = 1'b0;
        last_edge = cyc;
        j_res_at_start = result;
        while (i < n) begin
            @(negedge clk);
            if (gapc > 0) begin
                in_valid = 1'b0;
                gapc--;
                if (mid_start && !started_mid) begin
                    start = 1'b1;
                    len   = LW'(5);
                    started_mid = 1;
                end
            end else begin
                in_valid = 1'b1;
                x = DW'(px[i]);
                y = DW'(py[i]);
            end
            if (busy !== 1'b1) j_busy_bad = 1;
            if (!in_valid && in_ready !== 1'b1) j_gap_bad = 1;
            beat = in_valid && (in_ready === 1'b1);
            @(posedge clk);
            #1;
            start = 1'b0;
            if (beat) begin
                i++;
                last_edge = cyc;
                gapc = $urandom_range(gap_max, gap_min);
            end
            guard++;
            if (guard > 400) begin
                j_timeout = 1;
                break;
            end
        end
        // Garbage operands offered while the controller is not accepting must be ignored
        in_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            x = DW'($urandom);
            y = DW'($urandom);
            @(negedge clk);
            if (done === 1'b1) begin
                j_done_cnt++;
                if (j_done_cnt == 1) begin
                    j_lat = cyc - last_edge;
                    j_res = result;
                    j_ovf = ovf;
                    if (busy !== 1'b0) j_busy_bad = 1;
                end
            end
            if (in_ready === 1'b1) j_extra = 1;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; len = LW'(3);
        in_valid = 1'b0; x = '0; y = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (result !== '0) begin n_fail++; $display("FAIL reset_result: got %0d expected 0", result); end
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_wins_start: got busy=%b in_ready=%b expected 0/0", busy, in_ready);
        end
    endtask

    task automatic check_job(input string name, input bit zero_len);
        logic [AW-1:0] er;
        logic          eo;
        er = exp_q.pop_front();
        eo = exp_ovf_q.pop_front();
        n_checks++; if (j_timeout) begin n_fail++; $display("FAIL %s_timeout: got stalled stream expected %0d beats", name, 0); end
        n_checks++; if (j_done_cnt != 1) begin n_fail++; $display("FAIL %s_done_count: got %0d expected 1", name, j_done_cnt); end
        n_checks++; if (j_res !== er) begin n_fail++; $display("FAIL %s_result: got %0d expected %0d", name, j_res, er); end
        n_checks++; if (j_ovf !== eo) begin n_fail++; $display("FAIL %s_ovf: got %b expected %b", name, j_ovf, eo); end
        n_checks++; if (zero_len ? (j_lat < 1 || j_lat > 2) : (j_lat != 2)) begin
            n_fail++; $display("FAIL %s_latency: got %0d expected %0d", name, j_lat, zero_len ? 1 : 2);
        end
        n_checks++; if (j_busy_bad || j_extra) begin
            n_fail++; $display("FAIL %s_busy_ready: got busy_bad=%b extra=%b expected 0/0", name, j_busy_bad, j_extra);
        end
    endtask

    task automatic test_back_to_back();
        px[0] = 1; py[0] = 2; px[1] = 1; py[1] = 3; px[2] = 1; py[2] = 5;
        push_expect(3);
        drive_job(3, 0, 0, 0);
        check_job("b2b", 0);
    endtask

    task automatic test_gaps();
        px[0] = 1; py[0] = 2; px[1] = 1; py[1] = 3; px[2] = 1; py[2] = 5;
        push_expect(3);
        drive_job(3, 2, 2, 0);
        n_checks++; if (j_gap_bad) begin n_fail++; $display("FAIL gaps_in_ready: got dropped expected 1 through gaps"); end
        check_job("gaps", 0);
    endtask

    task automatic test_zero_len();
        push_expect(0);
        drive_job(0, 0, 0, 0);
        n_checks++; if (j_res_at_start !== 8'd10) begin
            n_fail++; $display("FAIL zero_len_hold: got %0d expected 10", j_res_at_start);
        end
        check_job("zero_len", 1);
    endtask

    task automatic test_overflow();
        px[0] = 15; py[0] = 15; px[1] = 15; py[1] = 15;
        push_expect(2);
        drive_job(2, 0, 1, 0);
        check_job("overflow", 0);
    endtask

    task automatic test_full_len();
        for (int i = 0; i < 15; i++) begin
            px[i] = $urandom_range(15, 8);
            py[i] = $urandom_range(15, 0);
        end
        push_expect(15);
        drive_job(15, 0, 1, 0);
        check_job("full_len", 0);
    endtask

    task automatic test_reset_mid_job();
        int seen_done;
        seen_done = 0;
        @(negedge clk); start = 1'b1; len = LW'(3);
        @(posedge clk); #1; start = 1'b0;
        @(negedge clk); in_valid = 1'b1; x = 4'd4; y = 4'd4;
        @(posedge clk); #1; in_valid = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL abort_ctrl: got busy=%b in_ready=%b expected 0/0", busy, in_ready);
        end
        n_checks++; if (result !== '0 || ovf !== 1'b0) begin
            n_fail++; $display("FAIL abort_result: got %0d ovf=%b expected 0 ovf=0", result, ovf);
        end
        for (int c = 0; c < 8; c++) begin
            if (done === 1'b1) seen_done++;
            @(negedge clk);
        end
        n_checks++; if (seen_done != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses expected 0", seen_done); end
        px[0] = 2; py[0] = 3;
        push_expect(1);
        drive_job(1, 0, 0, 0);
        check_job("after_abort", 0);
    endtask

    task automatic test_start_ignored();
        px[0] = 3; py[0] = 3; px[1] = 2; py[1] = 2;
        push_expect(2);
        drive_job(2, 1, 1, 1);
        check_job("start_ignored", 0);
    endtask

    task automatic test_random();
        int            n;
        logic [AW-1:0] prev;
        prev = result;
        for (int j = 0; j < 15; j++) begin
            n = $urandom_range(15, 0);
            for (int i = 0; i < 16; i++) begin
                px[i] = $urandom_range(15, 0);
                py[i] = $urandom_range(15, 0);
            end
            push_expect(n);
            drive_job(n, 0, 2, 0);
            n_checks++; if (j_res_at_start !== prev) begin
                n_fail++; $display("FAIL rand_hold_%0d: got %0d expected %0d", j, j_res_at_start, prev);
            end
            prev = exp_q[0];
            check_job($sformatf("rand_%0d", j), n == 0);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_gaps();
        test_zero_len();
        test_overflow();
        test_full_len();
        test_reset_mid_job();
        test_start_ignored();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
